vending_machine_multi: RTL and testbench
========================================

# vending_machine_multi

Parametrised successor to the single-coin vending controller. Accepts coins of several denominations through a valid/ready port and accumulates credit against a configurable price. When the price is reached it dispenses with change; on cancel it refunds the held credit. It also keeps a wrapping count of completed sales. It sits between the coin-acceptor front end and the dispenser/change-hopper back end, and both back-end outputs are valid/ready handshakes.

## Interface
- PRICE, 4: item price in coin units; must be ≥1.
- VAL_W, 2: coin value width; coin values are 0..2^VAL_W-1.
- CREDIT_W, 4: credit register width; must satisfy 2^CREDIT_W > PRICE-1 + 2^VAL_W-1.
- COUNT_W, 8: sale counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_coin_valid  in  1  a coin is presented.
- io_coin_value  in  VAL_W  value of the presented coin.
- io_coin_ready  out  1  coin is accepted when valid&&ready.
- io_cancel  in  1  request a refund of the held credit.
- io_dispense_valid  out  1  item plus change are pending.
- io_dispense_ready  in  1  dispenser accepts.
- io_change  out  CREDIT_W  change due; meaningful only while io_dispense_valid.
- io_refund_valid  out  1  refund is pending.
- io_refund_ready  in  1  hopper accepts.
- io_refund_value  out  CREDIT_W  refund amount; meaningful only while io_refund_valid.
- io_sales  out  COUNT_W  number of completed dispenses, wrapping.

## Operation
- States: IDLE (credit=0), COLLECT (0<credit<PRICE), DISPENSE, REFUND.
- io_coin_ready=1 exactly in IDLE and COLLECT. It is a function of state only, with no combinational path from inputs.
- Accepted coin: next = credit + io_coin_value, computed at CREDIT_W width with no overflow by the parameter constraint.
  - next ≥ PRICE → DISPENSE with io_change = next − PRICE.
  - 0 < next < PRICE → COLLECT.
  - next = 0 (a zero-value coin in IDLE) → stay in IDLE.
- io_cancel in IDLE/COLLECT: the refund amount is credit plus any coin accepted in the same cycle.
  - Amount > 0 → REFUND with io_refund_value = amount.
  - Amount = 0 → stay in IDLE.
- Cancel with a same-cycle coin that reaches PRICE: the sale wins. Go to DISPENSE and ignore the cancel.
- io_cancel is ignored in DISPENSE and REFUND.
- DISPENSE: io_dispense_valid=1, with io_change held stable until handshake.
  - On valid&&ready: go to IDLE, set credit=0 and io_change=0, and increment io_sales modulo 2^COUNT_W.
- REFUND: io_refund_valid=1, with io_refund_value held stable until handshake.
  - On valid&&ready: go to IDLE, set credit=0 and io_refund_value=0. io_sales is unchanged.
- io_dispense_valid and io_refund_valid are never high together.
- Reset, including reset mid-handshake:
  - state IDLE, credit 0, io_sales 0.
  - io_coin_ready=1 in the cycle after reset deasserts.
  - All other outputs 0; any pending dispense or refund is dropped.

## Timing
- Coin accepted at edge N → credit and state updated at N+1. io_coin_ready=0 from N+1 if DISPENSE is entered.
- Minimum sale latency: single coin ≥ PRICE accepted at N → io_dispense_valid=1 at N+1.
- Handshake completes at edge M → valid low and io_coin_ready high at M+1, giving one idle-acceptance cycle before the next sale can begin.
- Valid outputs are held indefinitely while ready=0, and payload does not change.
- io_sales updates at the edge following the dispense handshake.
- All outputs are registered or decoded from registered state only.

## Test plan
- Defaults, coins 1,1,1,1 on consecutive cycles → io_dispense_valid rises the cycle after the 4th coin, io_change=0. Hold ready=1 → io_sales=1 and IDLE next cycle.
- Coins 3 then 3 → DISPENSE with io_change=2. Hold io_dispense_ready=0 for 5 cycles → valid and change stable, io_coin_ready=0, cancel ignored. Then ready=1 → io_sales increments.
- Coin 2, then io_cancel with coin 1 in the same cycle → REFUND with io_refund_value=3. Handshake → IDLE, io_sales unchanged.
- Coin 3 with io_cancel in the same cycle from credit 1 (sum 4) → DISPENSE with io_change=0, no refund.
- Cancel in IDLE, and a zero-value coin in IDLE → stay in IDLE, no valid outputs.
- COUNT_W=2, four complete sales → io_sales wraps 3→0.
- Assert reset during DISPENSE → next cycle all outputs 0 except io_coin_ready=1, and the pending item is not counted.

Source files
------------

// File: rtl/vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module   : vending_machine_multi
// Brief    : Multi-denomination vending controller. Coins arrive through a
//            valid/ready port and build up credit against PRICE. Reaching the
//            price dispenses the item with change, and a cancel refunds the
//            held credit. Both back-end outputs are valid/ready handshakes.
//            A wrapping counter records the completed sales.
// Revision : 1.0 - initial release
// ============================================================================
module vending_machine_multi #(
    parameter int PRICE    = 4,   // item price in coin units, >= 1
    parameter int VAL_W    = 2,   // coin value width
    parameter int CREDIT_W = 4,   // credit width, 2^CREDIT_W > PRICE-1 + 2^VAL_W-1
    parameter int COUNT_W  = 8    // sale counter width
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_coin_valid,
    input  logic [VAL_W-1:0]    io_coin_value,
    output logic                io_coin_ready,
    input  logic                io_cancel,
    output logic                io_dispense_valid,
    input  logic                io_dispense_ready,
    output logic [CREDIT_W-1:0] io_change,
    output logic                io_refund_valid,
    input  logic                io_refund_ready,
    output logic [CREDIT_W-1:0] io_refund_value,
    output logic [COUNT_W-1:0]  io_sales
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE     = 2'd0;   // credit == 0
    localparam logic [1:0] c_COLLECT  = 2'd1;   // 0 < credit < PRICE
    localparam logic [1:0] c_DISPENSE = 2'd2;   // item + change pending
    localparam logic [1:0] c_REFUND   = 2'd3;   // refund pending

    // Price at credit width. The parameter constraint guarantees it fits.
    localparam logic [CREDIT_W-1:0] c_PRICE = CREDIT_W'(PRICE);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_change;
    logic [CREDIT_W-1:0] r_refund;
    logic [COUNT_W-1:0]  r_sales;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]          w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W-1:0] w_change_nxt;
    logic [CREDIT_W-1:0] w_refund_nxt;
    logic [COUNT_W-1:0]  w_sales_nxt;

    // Coin acceptance is decoded from state alone, so the front end never
    // sees a combinational path from its own valid back to ready.
    logic                w_accepting;
    logic                w_coin_fire;
    logic [CREDIT_W-1:0] w_coin_ext;
    logic [CREDIT_W-1:0] w_sum;

    assign w_accepting = (r_state == c_IDLE) || (r_state == c_COLLECT);
    assign w_coin_fire = w_accepting && io_coin_valid;
    assign w_coin_ext  = w_coin_fire ? CREDIT_W'(io_coin_value) : '0;

    // Credit plus any coin taken this cycle. This sum covers both the sale
    // check and the refund amount when cancel and a coin coincide.
    assign w_sum = r_credit + w_coin_ext;

    // ------------------------------------------------------------------------
    // State register: all architectural state updates on the rising edge
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_credit <= '0;
            r_change <= '0;
            r_refund <= '0;
            r_sales  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_change <= w_change_nxt;
            r_refund <= w_refund_nxt;
            r_sales  <= w_sales_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: coin accumulation, sale/cancel priority, handshakes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_change_nxt = r_change;
        w_refund_nxt = r_refund;
        w_sales_nxt  = r_sales;

        case (r_state)
            c_IDLE, c_COLLECT: begin
                if (w_sum >= c_PRICE) begin
                    // A sale takes priority over a same-cycle cancel.
                    w_state_nxt  = c_DISPENSE;
                    w_change_nxt = w_sum - c_PRICE;
                    w_credit_nxt = '0;
                end else if (io_cancel) begin
                    w_credit_nxt = '0;
                    if (w_sum != '0) begin
                        w_state_nxt  = c_REFUND;
                        w_refund_nxt = w_sum;
                    end else begin
                        w_state_nxt  = c_IDLE;
                    end
                end else begin
                    // A zero-value coin in IDLE leaves the credit at zero.
                    w_credit_nxt = w_sum;
                    w_state_nxt  = (w_sum == '0) ? c_IDLE : c_COLLECT;
                end
            end

            c_DISPENSE: begin
                // Cancel is ignored here, and the change stays stable until accepted.
                if (io_dispense_ready) begin
                    w_state_nxt  = c_IDLE;
                    w_credit_nxt = '0;
                    w_change_nxt = '0;
                    w_sales_nxt  = r_sales + COUNT_W'(1);
                end
            end

            c_REFUND: begin
                if (io_refund_ready) begin
                    w_state_nxt  = c_IDLE;
                    w_credit_nxt = '0;
                    w_refund_nxt = '0;
                end
            end

            default: begin
                w_state_nxt  = c_IDLE;
                w_credit_nxt = '0;
                w_change_nxt = '0;
                w_refund_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode: every output comes from registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        io_coin_ready     = w_accepting;
        io_dispense_valid = (r_state == c_DISPENSE);
        io_refund_valid   = (r_state == c_REFUND);
        io_change         = r_change;
        io_refund_value   = r_refund;
        io_sales          = r_sales;
    end

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_machine_multi
// Brief    : Directed bench for vending_machine_multi. It drives a default
//            instance and a COUNT_W=2 instance with the same stimulus and
//            checks both against a credit/pending-payload model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_machine_multi;

    localparam int PRICE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       cancel;
    logic       dispense_ready;
    logic       refund_ready;

    logic       coin_ready,  coin_ready_w;
    logic       disp_valid,  disp_valid_w;
    logic [3:0] change,      change_w;
    logic       ref_valid,   ref_valid_w;
    logic [3:0] ref_value,   ref_value_w;
    logic [7:0] sales;
    logic [1:0] sales_w;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model: credit as an integer, plus what is pending (0 none, 1 dispense, 2 refund).
    int m_credit  = 0;
    int m_pending = 0;
    int m_amount  = 0;
    int m_sales   = 0;

    always #5 clk = ~clk;

    vending_machine_multi dut (
        .clk(clk), .reset(reset),
        .io_coin_valid(coin_valid), .io_coin_value(coin_value), .io_coin_ready(coin_ready),
        .io_cancel(cancel),
        .io_dispense_valid(disp_valid), .io_dispense_ready(dispense_ready), .io_change(change),
        .io_refund_valid(ref_valid), .io_refund_ready(refund_ready), .io_refund_value(ref_value),
        .io_sales(sales)
    );

    vending_machine_multi #(.COUNT_W(2)) dut_w (
        .clk(clk), .reset(reset),
        .io_coin_valid(coin_valid), .io_coin_value(coin_value), .io_coin_ready(coin_ready_w),
        .io_cancel(cancel),
        .io_dispense_valid(disp_valid_w), .io_dispense_ready(dispense_ready), .io_change(change_w),
        .io_refund_valid(ref_valid_w), .io_refund_ready(refund_ready), .io_refund_value(ref_value_w),
        .io_sales(sales_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Apply one edge of the machine's rules to the model.
    task automatic model_step();
        int total;
        if (reset) begin
            m_credit = 0; m_pending = 0; m_amount = 0; m_sales = 0;
        end else if (m_pending == 0) begin
            total = m_credit + (coin_valid ? int'(coin_value) : 0);
            if (total >= PRICE) begin
                m_pending = 1; m_amount = total - PRICE; m_credit = 0;
            end else if (cancel) begin
                m_credit = 0;
                if (total > 0) begin
                    m_pending = 2; m_amount = total;
                end
            end else begin
                m_credit = total;
            end
        end else if (m_pending == 1) begin
            if (dispense_ready) begin
                m_pending = 0; m_amount = 0; m_sales++;
            end
        end else if (refund_ready) begin
            m_pending = 0; m_amount = 0;
        end
    endtask

    // One clock: drive inputs, update the model at the edge, settle 1 time unit later.
    task automatic cyc(input bit rst, input bit cv, input logic [1:0] val,
                       input bit can, input bit dr, input bit rr);
        reset = rst; coin_valid = cv; coin_value = val; cancel = can;
        dispense_ready = dr; refund_ready = rr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("coin_ready",   coin_ready,   m_pending == 0);
            chk("disp_valid",   disp_valid,   m_pending == 1);
            chk("change",       change,       (m_pending == 1) ? m_amount : 0);
            chk("ref_valid",    ref_valid,    m_pending == 2);
            chk("ref_value",    ref_value,    (m_pending == 2) ? m_amount : 0);
            chk("sales",        sales,        m_sales % 256);
            chk("w_disp_valid", disp_valid_w, m_pending == 1);
            chk("w_ref_valid",  ref_valid_w,  m_pending == 2);
            chk("w_sales",      sales_w,      m_sales % 4);
            chk("one_hot_valid", disp_valid & ref_valid, 0);
        end
    end

    initial begin
        reset = 1'b1; coin_valid = 0; coin_value = 0; cancel = 0;
        dispense_ready = 0; refund_ready = 0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check_en = 1'b1;
        chk("lit_reset_ready", coin_ready, 1);
        chk("lit_reset_sales", sales, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Four unit coins reach the price exactly, and the change is zero.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("lit_no_disp_after_3", disp_valid, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("lit_disp_after_4", disp_valid, 1);
        chk("lit_change_0", change, 0);
        chk("lit_ready_low", coin_ready, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_sales_1", sales, 1);
        chk("lit_idle_ready", coin_ready, 1);

        // 3 + 3: change of 2 is held during back-pressure while cancel and coins are ignored.
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0);
        chk("lit_change_2", change, 2);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, 0);
        chk("lit_change_hold", change, 2);
        chk("lit_disp_hold", disp_valid, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_sales_2", sales, 2);

        // Coin 2, then cancel together with coin 1, refunds 3.
        cyc(0, 1, 2, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        chk("lit_refund_3", ref_value, 3);
        chk("lit_refund_valid", ref_valid, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("lit_sales_after_refund", sales, 2);

        // Credit 1, then coin 3 with cancel: the sale wins with zero change.
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 3, 1, 0, 0);
        chk("lit_sale_wins", disp_valid, 1);
        chk("lit_no_refund", ref_valid, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // Cancel in IDLE and a zero-value coin in IDLE both leave the machine idle.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 1);
        chk("lit_idle_stays", coin_ready, 1);

        // Fourth sale wraps the narrow counter. A coin during the handshake is not taken.
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 3, 0, 1, 0);
        chk("lit_sales_4", sales, 4);
        chk("lit_wrap_0", sales_w, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Reset during DISPENSE with ready high drops the pending item.
        cyc(0, 1, 3, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0);
        chk("lit_change_1", change, 1);
        cyc(1, 0, 0, 0, 1, 0);
        chk("lit_rst_disp", disp_valid, 0);
        chk("lit_rst_change", change, 0);
        chk("lit_rst_ready", coin_ready, 1);
        chk("lit_rst_sales", sales, 0);

        // Sale with ready already high: one dispense cycle, then a one-cycle handshake.
        cyc(0, 1, 3, 0, 1, 0);
        cyc(0, 1, 3, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("lit_sales_after_rst", sales, 1);

        // Refund interrupted by reset.
        cyc(0, 1, 2, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        chk("lit_rst_refund", ref_valid, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
